ll_axis_rx_framer: RTL and testbench

// - LocalLink-to-AXI4-Stream receive bridge with framing repair. It sits directly downstream of an
//   AXI-Stream-to-LocalLink bridge or any LocalLink source, and feeds AXI-Stream logic.
// - It converts SOF/EOF framing into tlast and drops beats that arrive outside a frame.
// - It closes truncated frames (SOF seen before EOF) with tlast=1, tuser=1, using a one-beat hold register.

---
 rtl/ll_axis_rx_framer_if.sv | 21 ++
 rtl/ll_axis_rx_framer.sv | 92 +++++++++
 tb/tb_ll_axis_rx_framer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_axis_rx_framer_if.sv
// ll_axis_rx_framer_if: LocalLink input and AXI-Stream output bundle for the rx framer.
interface ll_axis_rx_framer_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] ll_data_in;
  logic                  ll_sof_in_n;
  logic                  ll_eof_in_n;
  logic                  ll_src_rdy_in_n;
  logic                  ll_dst_rdy_out_n;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;
  modport master (
    input  ll_data_in, ll_sof_in_n, ll_eof_in_n, ll_src_rdy_in_n, m_axis_tready,
    output ll_dst_rdy_out_n, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
  modport slave (
    output ll_data_in, ll_sof_in_n, ll_eof_in_n, ll_src_rdy_in_n, m_axis_tready,
    input  ll_dst_rdy_out_n, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/ll_axis_rx_framer.sv
// ll_axis_rx_framer: LocalLink to AXI-Stream bridge that drops out-of-frame beats and closes truncated frames.
// Define LL_AXIS_RX_FRAMER_STATS_EN to build the saturating drop/truncation counters.
module ll_axis_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ll_axis_rx_framer_if.master   bus,
  output logic                  drop_beat,
  output logic [STAT_WIDTH-1:0] stat_drop_count,
  output logic [STAT_WIDTH-1:0] stat_trunc_count
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d, o_data_q, o_data_d;
  logic h_last_q, h_last_d, h_valid_q, h_valid_d;
  logic o_valid_q, o_valid_d, o_last_q, o_last_d, o_user_q, o_user_d;
  logic drop_q, drop_d;
  logic sof, eof, o_free, rdy, accept, drop, trunc, load, drain;
  // H can only take a new beat if it is empty or can hand its current beat to O this cycle
  always_comb begin
    sof       = !bus.ll_sof_in_n;
    eof       = !bus.ll_eof_in_n;
    o_free    = !o_valid_q || bus.m_axis_tready;
    rdy       = !h_valid_q || o_free;
    accept    = !bus.ll_src_rdy_in_n && rdy && !rst;
    drop      = accept && state_q == IDLE && !sof;
    trunc     = accept && state_q == ACTIVE && sof;
    load      = accept && !drop;
    drain     = o_free && h_valid_q && (h_last_q || accept);
    state_d   = load ? (eof ? IDLE : ACTIVE) : state_q;
    h_data_d  = load ? bus.ll_data_in : h_data_q;
    h_last_d  = load ? eof : h_last_q;
    h_valid_d = load || (h_valid_q && !drain);
    o_valid_d = drain || (o_valid_q && !bus.m_axis_tready);
    o_data_d  = drain ? h_data_q : o_data_q;
    o_last_d  = drain ? (h_last_q || trunc) : o_last_q;
    o_user_d  = drain ? trunc : o_user_q;
    drop_d    = drop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      h_data_q  <= '0;
      h_last_q  <= 1'b0;
      h_valid_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_user_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_data_q  <= h_data_d;
      h_last_q  <= h_last_d;
      h_valid_q <= h_valid_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_user_q  <= o_user_d;
      drop_q    <= drop_d;
    end
  end
  assign bus.ll_dst_rdy_out_n = rst || !rdy;
  assign bus.m_axis_tvalid    = o_valid_q;
  assign bus.m_axis_tdata     = o_data_q;
  assign bus.m_axis_tlast     = o_last_q;
  assign bus.m_axis_tuser     = o_user_q;
  assign drop_beat            = drop_q;
`ifdef LL_AXIS_RX_FRAMER_STATS_EN
  logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, trunc_cnt_q, trunc_cnt_d;
  always_comb begin
    drop_cnt_d  = (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    trunc_cnt_d = (trunc && !(&trunc_cnt_q)) ? trunc_cnt_q + 1'b1 : trunc_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end
  assign stat_drop_count  = drop_cnt_q;
  assign stat_trunc_count = trunc_cnt_q;
`else
  assign stat_drop_count  = '0;
  assign stat_trunc_count = '0;
`endif
endmodule

// File: tb/tb_ll_axis_rx_framer.sv
// tb_ll_axis_rx_framer: scoreboard bench for the LocalLink to AXI-Stream rx framer.
module tb_ll_axis_rx_framer;
  typedef struct packed {logic [7:0] d; logic l; logic u;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop_beat;
  logic [15:0] stat_drop_count, stat_trunc_count;
  exp_t q[$];
  int xfer_cyc[$];
  int total = 0, bad = 0, cyc = 0, drop_seen = 0, exp_drops = 0, exp_trunc = 0;
  logic open = 1'b0, toggle_en = 1'b0, chk_stall = 1'b0;
  logic [7:0] pend = '0;

  ll_axis_rx_framer_if #(.DATA_WIDTH(8)) bus ();

  ll_axis_rx_framer #(.DATA_WIDTH(8), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .drop_beat(drop_beat),
    .stat_drop_count(stat_drop_count), .stat_trunc_count(stat_trunc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (toggle_en) bus.m_axis_tready = ~bus.m_axis_tready;
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && drop_beat) drop_seen++;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got data=%h last=%b user=%b want nothing", bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser);
      end else begin
        e = q.pop_front();
        if ({bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser} !== {e.d, e.l, e.u}) begin
          bad++;
          $display("FAIL beat got data=%h last=%b user=%b want data=%h last=%b user=%b", bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, e.d, e.l, e.u);
        end
        xfer_cyc.push_back(cyc);
      end
    end
    if (!rst && bus.m_axis_tready) begin
      total++;
      if (bus.ll_dst_rdy_out_n !== 1'b0) begin
        bad++;
        $display("FAIL dst_rdy_when_o_free got=%b want=0", bus.ll_dst_rdy_out_n);
      end
    end
    if (!rst && chk_stall && open && bus.m_axis_tvalid && !bus.m_axis_tready) begin
      total++;
      if (bus.ll_dst_rdy_out_n !== 1'b1) begin
        bad++;
        $display("FAIL dst_rdy_when_stalled got=%b want=1", bus.ll_dst_rdy_out_n);
      end
    end
  end

  // Frame-level reference: a non-last beat is only known once its successor arrives
  task automatic model(input logic [7:0] d, input logic s, input logic e);
    if (!open && !s) exp_drops++;
    else begin
      if (open && s) begin
        q.push_back(exp_t'{pend, 1'b1, 1'b1});
        exp_trunc++;
        open = 1'b0;
      end
      if (!open) begin
        if (e) q.push_back(exp_t'{d, 1'b1, 1'b0});
        else begin pend = d; open = 1'b1; end
      end else begin
        q.push_back(exp_t'{pend, 1'b0, 1'b0});
        if (e) begin q.push_back(exp_t'{d, 1'b1, 1'b0}); open = 1'b0; end
        else pend = d;
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    logic acc = 1'b0;
    bus.ll_data_in = d;
    bus.ll_sof_in_n = !s;
    bus.ll_eof_in_n = !e;
    bus.ll_src_rdy_in_n = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = !bus.ll_dst_rdy_out_n;
      @(posedge clk);
      #1;
      n++;
    end
    bus.ll_src_rdy_in_n = 1'b1;
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout data=%h got=not_accepted want=accepted", d);
    end else model(d, s, e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want=0", q.size());
    end
  endtask

  task automatic check_consecutive(input int start, input int n, input string name);
    total++;
    if (xfer_cyc.size() < start + n || xfer_cyc[start+n-1] - xfer_cyc[start] != n - 1) begin
      bad++;
      $display("FAIL %s beats=%0d want %0d consecutive", name, xfer_cyc.size() - start, n);
    end
  endtask

  task automatic check_stats(input string name);
`ifdef LL_AXIS_RX_FRAMER_STATS_EN
    total++;
    if (stat_drop_count !== 16'(exp_drops) || stat_trunc_count !== 16'(exp_trunc)) begin
      bad++;
      $display("FAIL %s drop=%0d trunc=%0d want drop=%0d trunc=%0d", name, stat_drop_count, stat_trunc_count, exp_drops, exp_trunc);
    end
`else
    total++;
    if (stat_drop_count !== 16'd0 || stat_trunc_count !== 16'd0) begin
      bad++;
      $display("FAIL %s drop=%0d trunc=%0d want 0 0", name, stat_drop_count, stat_trunc_count);
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, drop_beat, bus.ll_dst_rdy_out_n} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%h l=%b u=%b drop=%b rdy_n=%b want 0 00 0 0 0 1", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, drop_beat, bus.ll_dst_rdy_out_n);
    end
    check_stats("reset_stats");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_frame4();
    int n0 = xfer_cyc.size();
    send_beat(8'hA0, 1, 0);
    send_beat(8'hA1, 0, 0);
    send_beat(8'hA2, 0, 0);
    send_beat(8'hA3, 0, 1);
    wait_drain();
    check_consecutive(n0, 4, "frame4_bubble");
  endtask

  task automatic test_single();
    send_beat(8'h5A, 1, 1);
    total++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got tvalid=%b want=0", bus.m_axis_tvalid);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_latency got v=%b d=%h l=%b u=%b want 1 5a 1 0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser);
    end
    wait_drain();
  endtask

  task automatic test_drop();
    int d0 = drop_seen;
    send_beat(8'h11, 0, 0);
    send_beat(8'h22, 0, 0);
    wait_drain();
    total++;
    if (drop_seen - d0 != 2) begin
      bad++;
      $display("FAIL drop_pulses got=%0d want=2", drop_seen - d0);
    end
    check_stats("drop_stats");
  endtask

  task automatic test_trunc();
    send_beat(8'h01, 1, 0);
    send_beat(8'h02, 0, 0);
    send_beat(8'h03, 1, 0);
    send_beat(8'h04, 0, 1);
    wait_drain();
    check_stats("trunc_stats");
  endtask

  task automatic test_stall();
    chk_stall = 1'b1;
    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(8'hB0 + 8'(i), i == 0, i == 7);
    wait_drain();
    toggle_en = 1'b0;
    chk_stall = 1'b0;
    bus.m_axis_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n0 = xfer_cyc.size();
    for (int i = 0; i < 8; i++) send_beat(8'hC0 + 8'(i), i == 0, i == 7);
    wait_drain();
    check_consecutive(n0, 8, "b2b_throughput");
  endtask

  task automatic test_reset_mid();
    bus.m_axis_tready = 1'b0;
    send_beat(8'hD0, 1, 0);
    send_beat(8'hD1, 0, 0);
    rst = 1'b1;
    #1;
    total++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.ll_dst_rdy_out_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got tvalid=%b rdy_n=%b want 0 1", bus.m_axis_tvalid, bus.ll_dst_rdy_out_n);
    end
    q.delete();
    open = 1'b0;
    exp_drops = 0;
    exp_trunc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    send_beat(8'hE0, 1, 0);
    send_beat(8'hE1, 0, 0);
    send_beat(8'hE2, 0, 1);
    wait_drain();
    check_stats("reset_mid_stats");
  endtask

  initial begin
    bus.ll_data_in = '0;
    bus.ll_sof_in_n = 1'b1;
    bus.ll_eof_in_n = 1'b1;
    bus.ll_src_rdy_in_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_frame4();
    test_single();
    test_drop();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
